// File: rtl/serial_sample_receiver.sv
// Receive end of the SCL/SS/MOSI sample link: oversampled deserializer feeding a FWFT FIFO.
// Optional RX_TIMEOUT_EN macro adds a stalled-frame timeout that discards the frame and enters ABORT.
module serial_sample_receiver #(
  parameter int DEPTH          = 8,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCL,
  input  logic             SS,
  input  logic             MOSI,
  input  logic             sample_ready,
  input  logic             clear_flags,
  output logic [11:0]      sample_out,
  output logic             sample_valid,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             frame_error
);

  // state | meaning
  // IDLE  | waiting for an SS falling edge
  // SHIFT | frame open, shifting one bit per SCL rising edge
  // DONE  | frame closed; push if exactly 12 bits, otherwise flag error
  // ABORT | frame timed out; wait for SS high
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ABORT} state_t;

  localparam int PTR_W = $clog2(DEPTH);

  if (CNT_W != $clog2(DEPTH) + 1) begin : g_bad_cnt_w
    $error("CNT_W must equal log2(DEPTH)+1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic r_scl_s1, r_scl_s2, r_scl_s3;
  logic r_ss_s1, r_ss_s2, r_ss_s3;
  logic r_mosi_s1, r_mosi_s2;

  // SS sync resets low so a frame already open at reset release is not seen as a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s1  <= 1'b0;
      r_scl_s2  <= 1'b0;
      r_scl_s3  <= 1'b0;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_s3   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_scl_s1  <= SCL;
      r_scl_s2  <= r_scl_s1;
      r_scl_s3  <= r_scl_s2;
      r_ss_s1   <= SS;
      r_ss_s2   <= r_ss_s1;
      r_ss_s3   <= r_ss_s2;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  logic w_scl_rise, w_ss_rise, w_ss_fall;
  assign w_scl_rise = r_scl_s2 & ~r_scl_s3;
  assign w_ss_rise  = r_ss_s2 & ~r_ss_s3;
  assign w_ss_fall  = ~r_ss_s2 & r_ss_s3;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [11:0] r_shift, w_shift_nxt;
  logic        w_push, w_err;
  logic        r_frame_error;

`ifdef RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] r_tmr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (r_state != SHIFT || w_scl_rise) begin
      r_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - TMR_W'(1);
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_bit_cnt_nxt = 4'd0;
          w_shift_nxt   = 12'd0;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // A coincident SCL edge is shifted in before the frame closes.
        if (w_scl_rise) begin
          w_shift_nxt = {r_shift[10:0], r_mosi_s2};
          if (r_bit_cnt != 4'd13) w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end
        if (w_ss_rise) begin
          w_state_nxt = DONE;
        end
`ifdef RX_TIMEOUT_EN
        else if (!w_scl_rise && r_tmr == '0) begin
          w_err       = 1'b1;
          w_state_nxt = ABORT;
        end
`endif
      end
      DONE: begin
        if (r_bit_cnt == 4'd12) w_push = 1'b1;
        else                    w_err  = 1'b1;
        w_state_nxt = IDLE;
      end
      ABORT: begin
        if (r_ss_s2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 12'd0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_frame_error <= w_err;
    end
  end

  logic [11:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_full, w_pop, w_wr_en, w_ovf_set;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop     = sample_valid & sample_ready;
  // When full, a same-cycle pop frees the slot the write pointer is aimed at.
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (clear_flags) r_overflow <= 1'b0;
    end
  end

  assign sample_valid = (r_count != '0);
  assign sample_out   = sample_valid ? r_mem[r_rd_ptr] : 12'd0;
  assign fifo_count   = r_count;
  assign overflow     = r_overflow;
  assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_serial_sample_receiver.sv
// Randomized bench for serial_sample_receiver against a queue-based model of the link and FIFO.
// Timeout scenario runs only when RX_TIMEOUT_EN is defined.
module tb_serial_sample_receiver;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int TMO   = 2500;

  logic             clk = 1'b0;
  logic             rst, scl, ss, mosi, rdy, clr;
  logic [11:0]      sample_out;
  logic             sample_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow, frame_error;

  always #10 clk = ~clk;

  serial_sample_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .SCL(scl), .SS(ss), .MOSI(mosi),
    .sample_ready(rdy), .clear_flags(clr),
    .sample_out(sample_out), .sample_valid(sample_valid), .fifo_count(fifo_count),
    .overflow(overflow), .frame_error(frame_error)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          err_seen = 0;
  int          err_exp  = 0;
  int          cyc      = 0;
  logic [11:0] q[$];
  bit          ovf_m = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (frame_error === 1'b1) err_seen++;
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: run did not finish, limit %0d cycles", 200000);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cnt"},  32'(fifo_count), 32'(q.size()));
    chk({tag, "_vld"},  32'(sample_valid), 32'(q.size() != 0));
    chk({tag, "_out"},  32'(sample_out), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk({tag, "_ovf"},  32'(overflow), 32'(ovf_m));
    chk({tag, "_ferr"}, 32'(err_seen), 32'(err_exp));
  endtask

  // Frame outcome from the link rules: only exactly-12-bit frames carry a word.
  task automatic model_frame(input logic [15:0] word, input int nbits, input bit pop_same);
    bit full_before;
    full_before = (q.size() == DEPTH);
    if (pop_same && q.size() != 0) void'(q.pop_front());
    if (nbits != 12)                  err_exp++;
    else if (!full_before || pop_same) q.push_back(word[11:0]);
    else                              ovf_m = 1'b1;
  endtask

  task automatic send_bits(input logic [15:0] word, input int first, input int last, input int hp);
    for (int i = first; i < last; i++) begin
      mosi = word[15 - i];
      wait_clk(hp);
      scl = 1'b1;
      wait_clk(hp);
      scl = 1'b0;
    end
  endtask

  // word holds the frame left-aligned so bit 15 is sent first.
  task automatic send_frame(input logic [15:0] value, input int nbits, input int hp,
                            input bit lat_chk, input bit pop_at_push);
    logic [15:0] word;
    bit          was_empty;
    word = value << (16 - nbits);
    @(negedge clk);
    ss = 1'b0;
    wait_clk(hp);
    send_bits(word, 0, nbits, hp);
    wait_clk(hp);
    ss = 1'b1;
    was_empty = (q.size() == 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (lat_chk && was_empty && nbits == 12) begin
        if (k == 3) chk("lat3_vld", 32'(sample_valid), 32'd0);
        if (k == 4) begin
          chk("lat4_vld", 32'(sample_valid), 32'd1);
          chk("lat4_out", 32'(sample_out), 32'(value[11:0]));
        end
      end
      if (pop_at_push && k == 3) rdy = 1'b1;
      if (pop_at_push && k == 4) rdy = 1'b0;
    end
    model_frame(value, nbits, pop_at_push);
    wait_clk(3);
  endtask

  task automatic pop_one(input string tag);
    @(negedge clk);
    chk({tag, "_head"}, 32'(sample_out), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic drain_all(input string tag);
    int n;
    @(negedge clk);
    rdy = 1'b1;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_vld"}, 32'(sample_valid), 32'd1);
      chk({tag, "_out"}, 32'(sample_out), 32'(q[0]));
      void'(q.pop_front());
      @(negedge clk);
    end
    rdy = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ovf_m = 1'b0;
  endtask

  initial begin
    logic [15:0] word;
    rst = 1'b0; scl = 1'b0; ss = 1'b1; mosi = 1'b0; rdy = 1'b0; clr = 1'b0;
    wait_clk(3);
    check_state("rst");
    rst = 1'b1;
    wait_clk(5);

    send_frame(16'hA5C, 12, 6, 1'b1, 1'b0);
    check_state("single");
    pop_one("single_pop");
    check_state("single_popped");

    pop_one("empty_pop");
    check_state("empty_pop");

    for (int i = 1; i <= 8; i++) send_frame(16'(i), 12, $urandom_range(3, 8), 1'b1, 1'b0);
    check_state("fill8");
    drain_all("drain");
    check_state("drained");

    for (int i = 1; i <= 8; i++) send_frame(16'(i), 12, 4, 1'b0, 1'b0);
    send_frame(16'hFFF, 12, 4, 1'b0, 1'b0);
    check_state("ovf");
    pulse_clear();
    check_state("ovf_clr");

    send_frame(16'h5A5, 12, 4, 1'b0, 1'b1);
    check_state("full_pushpop");
    drain_all("drain2");

    send_frame(16'h7FF, 11, 5, 1'b0, 1'b0);
    check_state("short11");
    send_frame(16'h1ABC, 13, 5, 1'b0, 1'b0);
    check_state("long13");
    send_frame(16'h3C3, 12, 5, 1'b1, 1'b0);
    check_state("after_err");
    pop_one("after_err_pop");

    word = 16'hABC0;
    @(negedge clk);
    ss = 1'b0;
    wait_clk(5);
    send_bits(word, 0, 6, 5);
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    wait_clk(3);
    check_state("midrst");
    rst = 1'b1;
    send_bits(word, 6, 12, 5);
    wait_clk(5);
    ss = 1'b1;
    wait_clk(10);
    check_state("postrst");
    send_frame(16'h800, 12, 5, 1'b1, 1'b0);
    check_state("after_rst_frame");
    drain_all("drain3");

    for (int it = 0; it < 24; it++) begin
      int nb;
      int sel;
      sel = $urandom_range(0, 9);
      nb  = (sel == 0) ? 11 : (sel == 1) ? 13 : (sel == 2) ? 10 : 12;
      send_frame(16'($urandom), nb, $urandom_range(3, 8), 1'b1, 1'b0);
      check_state("rand");
      if ($urandom_range(0, 3) == 0) pop_one("rand_pop");
      if (ovf_m && $urandom_range(0, 1) == 1) pulse_clear();
    end
    drain_all("drain4");
    check_state("rand_end");

`ifdef RX_TIMEOUT_EN
    begin
      int t0;
      int e0;
      int waited;
      word = 16'hF0F0;
      e0 = err_seen;
      @(negedge clk);
      ss = 1'b0;
      wait_clk(5);
      send_bits(word, 0, 4, 5);
      mosi = word[11];
      wait_clk(5);
      scl = 1'b1;
      t0 = cyc;
      wait_clk(5);
      scl = 1'b0;
      waited = 0;
      while (err_seen == e0 && waited < TMO + 200) begin
        @(negedge clk);
        waited++;
      end
      chk("tmo_seen", 32'(err_seen - e0), 32'd1);
      chk("tmo_window", 32'((cyc - t0) >= TMO && (cyc - t0) <= TMO + 6), 32'd1);
      err_exp++;
      @(negedge clk);
      ss = 1'b1;
      wait_clk(10);
      check_state("tmo");
      send_frame(16'h2D2, 12, 5, 1'b1, 1'b0);
      check_state("tmo_next");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
